// File: rtl/vgachargen_console_writer_pkg.sv
// Shared constants and types for the console writer that feeds the vgachargen
// char_map/col_map write ports.
package vgachargen_console_writer_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_ADDR_W = 10;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} console_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/vgachargen_console_writer_if.sv
// Byte stream in, char_map/col_map write ports out. The writer is the stream
// slave; the byte source / map owner side uses the master modport.
interface vgachargen_console_writer_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid_i;
    logic              s_ready_o;
    logic [7:0]        s_data_i;
    logic [7:0]        s_color_i;
    logic [ADDR_W-1:0] char_map_addr_o;
    logic              char_map_we_o;
    logic [3:0]        char_map_be_o;
    logic [31:0]       char_map_wdata_o;
    logic [ADDR_W-1:0] col_map_addr_o;
    logic              col_map_we_o;
    logic [3:0]        col_map_be_o;
    logic [31:0]       col_map_wdata_o;

    modport slave (
        input  s_valid_i, s_data_i, s_color_i,
        output s_ready_o,
        output char_map_addr_o, char_map_we_o, char_map_be_o, char_map_wdata_o,
        output col_map_addr_o, col_map_we_o, col_map_be_o, col_map_wdata_o
    );

    modport master (
        output s_valid_i, s_data_i, s_color_i,
        input  s_ready_o,
        input  char_map_addr_o, char_map_we_o, char_map_be_o, char_map_wdata_o,
        input  col_map_addr_o, col_map_we_o, col_map_be_o, col_map_wdata_o
    );
endinterface

// File: rtl/vgachargen_console_writer.sv
// Turns a byte stream into char/colour cell writes at a hardware cursor, with
// control codes, line wrap, new-row clearing and full-screen clear.
module vgachargen_console_writer
    import vgachargen_console_writer_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    vgachargen_console_writer_if.slave bus,
    output logic [6:0]                 cursor_col_o,
    output logic [4:0]                 cursor_row_o,
    output logic                       busy_o
);
    localparam int WPR   = COLS / 4;
    localparam int WTOT  = COLS * ROWS / 4;
    localparam int POS_W = ADDR_W + 2;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    localparam logic [31:0] CLR_CHARS  = {4{ASCII_SPACE}};

    console_state_e    state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [CNT_W-1:0]  clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]  clr_end_q, clr_end_d;
    logic [7:0]        clr_color_q, clr_color_d;
    logic              ready_q;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       cdata_q, cdata_d;
    logic [31:0]       kdata_q, kdata_d;

    logic              accept;
    logic [4:0]        row_inc;
    logic [POS_W-1:0]  cell_pos;
    logic [POS_W-1:0]  bs_pos;
    logic [CNT_W-1:0]  row_base;

    assign accept   = bus.s_valid_i & ready_q;
    assign row_inc  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign cell_pos = POS_W'(int'(row_q) * COLS + int'(col_q));
    assign bs_pos   = cell_pos - POS_W'(1);
    assign row_base = CNT_W'(int'(row_inc) * WPR);

    // clr_end is exclusive: the cycle that finds clr_addr == clr_end writes nothing
    // and returns to IDLE, so ready comes back one cycle after the last clear word.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        clr_addr_d  = clr_addr_q;
        clr_end_d   = clr_end_q;
        clr_color_d = clr_color_q;
        we_d        = 1'b0;
        be_d        = '0;
        addr_d      = '0;
        cdata_d     = '0;
        kdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(bus.s_data_i)) begin
                        we_d    = 1'b1;
                        be_d    = 4'b0001 << cell_pos[1:0];
                        addr_d  = cell_pos[POS_W-1:2];
                        cdata_d = {4{bus.s_data_i}};
                        kdata_d = {4{bus.s_color_i}};
                        if (col_q == LAST_COL) begin
                            col_d       = '0;
                            row_d       = row_inc;
                            clr_addr_d  = row_base;
                            clr_end_d   = row_base + CNT_W'(WPR);
                            clr_color_d = bus.s_color_i;
                            state_d     = CLR_ROW;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (bus.s_data_i)
                            ASCII_LF: begin
                                // First clear word goes out with the handshake itself
                                col_d       = '0;
                                row_d       = row_inc;
                                we_d        = 1'b1;
                                be_d        = 4'hF;
                                addr_d      = row_base[ADDR_W-1:0];
                                cdata_d     = CLR_CHARS;
                                kdata_d     = {4{bus.s_color_i}};
                                clr_addr_d  = row_base + CNT_W'(1);
                                clr_end_d   = row_base + CNT_W'(WPR);
                                clr_color_d = bus.s_color_i;
                                state_d     = CLR_ROW;
                            end
                            ASCII_CR: col_d = '0;
                            ASCII_BS: begin
                                if (col_q != 7'd0) begin
                                    col_d   = col_q - 7'd1;
                                    we_d    = 1'b1;
                                    be_d    = 4'b0001 << bs_pos[1:0];
                                    addr_d  = bs_pos[POS_W-1:2];
                                    cdata_d = {4{ASCII_SPACE}};
                                    kdata_d = {4{bus.s_color_i}};
                                end
                            end
                            ASCII_FF: begin
                                col_d       = '0;
                                row_d       = '0;
                                we_d        = 1'b1;
                                be_d        = 4'hF;
                                addr_d      = '0;
                                cdata_d     = CLR_CHARS;
                                kdata_d     = {4{bus.s_color_i}};
                                clr_addr_d  = CNT_W'(1);
                                clr_end_d   = CNT_W'(WTOT);
                                clr_color_d = bus.s_color_i;
                                state_d     = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLR_ROW, CLR_ALL: begin
                if (clr_addr_q == clr_end_q) begin
                    state_d = IDLE;
                end else begin
                    we_d       = 1'b1;
                    be_d       = 4'hF;
                    addr_d     = clr_addr_q[ADDR_W-1:0];
                    cdata_d    = CLR_CHARS;
                    kdata_d    = {4{clr_color_q}};
                    clr_addr_d = clr_addr_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            clr_addr_q  <= '0;
            clr_end_q   <= '0;
            clr_color_q <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            cdata_q     <= '0;
            kdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            clr_addr_q  <= clr_addr_d;
            clr_end_q   <= clr_end_d;
            clr_color_q <= clr_color_d;
            ready_q     <= (state_d == IDLE);
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            cdata_q     <= cdata_d;
            kdata_q     <= kdata_d;
        end
    end

    assign bus.s_ready_o        = ready_q;
    assign bus.char_map_addr_o  = addr_q;
    assign bus.char_map_we_o    = we_q;
    assign bus.char_map_be_o    = be_q;
    assign bus.char_map_wdata_o = cdata_q;
    assign bus.col_map_addr_o   = addr_q;
    assign bus.col_map_we_o     = we_q;
    assign bus.col_map_be_o     = be_q;
    assign bus.col_map_wdata_o  = kdata_q;
    assign cursor_col_o         = col_q;
    assign cursor_row_o         = row_q;
    assign busy_o               = (state_q != IDLE);

endmodule

// File: tb/tb_vgachargen_console_writer.sv
// Randomized bench for the console writer against a screen-level reference model
// that predicts every write (cycle, address, lanes, data) and the ready/busy windows.
module tb_vgachargen_console_writer;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 10;
    localparam int WPR    = COLS / 4;
    localparam int NWORDS = COLS * ROWS / 4;
    localparam int NCELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       arstn = 1'b1;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    always #5 clk = ~clk;

    vgachargen_console_writer_if #(.ADDR_W(ADDR_W)) bus();

    vgachargen_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .bus          (bus),
        .cursor_col_o (cur_col),
        .cursor_row_o (cur_row),
        .busy_o       (busy)
    );

    typedef struct {
        int          cyc;
        int          addr;
        logic [3:0]  be;
        logic [31:0] cd;
        logic [31:0] kd;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ready_cyc = 0;
    int          m_col = 0;
    int          m_row = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  scr_ch[NCELLS];
    logic [7:0]  scr_co[NCELLS];
    logic [31:0] sh_ch[NWORDS];
    logic [31:0] sh_co[NWORDS];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_word(input int t, input int addr, input logic [3:0] be,
                             input logic [31:0] cd, input logic [31:0] kd);
        wr_t w;
        w.cyc = t; w.addr = addr; w.be = be; w.cd = cd; w.kd = kd;
        exp_q.push_back(w);
    endtask

    task automatic put_cell(input int t, input int pos, input logic [7:0] ch, input logic [7:0] co);
        push_word(t, pos / 4, 4'(1 << (pos % 4)), {4{ch}}, {4{co}});
        scr_ch[pos] = ch;
        scr_co[pos] = co;
    endtask

    // Clears the model's current row, words presented on consecutive cycles from t.
    task automatic clear_row(input int t, input logic [7:0] co);
        for (int k = 0; k < WPR; k++)
            push_word(t + k, m_row * WPR + k, 4'hF, 32'h2020_2020, {4{co}});
        for (int c = 0; c < COLS; c++) begin
            scr_ch[m_row * COLS + c] = 8'h20;
            scr_co[m_row * COLS + c] = co;
        end
        ready_cyc = t + WPR;
    endtask

    task automatic model_accept(input logic [7:0] b, input logic [7:0] co, input int acc);
        int pos;
        pos = m_row * COLS + m_col;
        ready_cyc = acc;
        if (b >= 8'h20 && b <= 8'h7E) begin
            put_cell(acc, pos, b, co);
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                clear_row(acc + 1, co);
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
            clear_row(acc, co);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                put_cell(acc, pos - 1, 8'h20, co);
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            for (int w = 0; w < NWORDS; w++)
                push_word(acc + w, w, 4'hF, 32'h2020_2020, {4{co}});
            for (int p = 0; p < NCELLS; p++) begin
                scr_ch[p] = 8'h20;
                scr_co[p] = co;
            end
            ready_cyc = acc + NWORDS;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] co);
        int guard;
        guard = 0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = b;
        bus.s_color_i = co;
        while (!bus.s_ready_o && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.s_ready_o) begin
            check_eq("ready_timeout", bus.s_ready_o, 1'b1);
            bus.s_valid_i = 1'b0;
            return;
        end
        model_accept(b, co, cyc + 1);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || cyc < ready_cyc); i++)
            @(negedge clk);
        check_eq("drain_pending_writes", exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (mon_en) begin
            check_eq("ready", bus.s_ready_o, cyc >= ready_cyc);
            check_eq("busy", busy, cyc < ready_cyc);
            check_eq("cursor", {cur_row, cur_col}, {5'(m_row), 7'(m_col)});
            check_eq("col_mirror", {bus.col_map_we_o, bus.col_map_be_o, bus.col_map_addr_o},
                     {bus.char_map_we_o, bus.char_map_be_o, bus.char_map_addr_o});
            if (bus.char_map_we_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_we", bus.char_map_we_o, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("write_cycle", cyc, mon_e.cyc);
                    check_eq("write", {bus.char_map_addr_o, bus.char_map_be_o,
                                       bus.char_map_wdata_o, bus.col_map_wdata_o},
                             {ADDR_W'(mon_e.addr), mon_e.be, mon_e.cd, mon_e.kd});
                end
                if (int'(bus.char_map_addr_o) < NWORDS) begin
                    for (int l = 0; l < 4; l++) begin
                        if (bus.char_map_be_o[l]) begin
                            sh_ch[bus.char_map_addr_o][8*l +: 8] = bus.char_map_wdata_o[8*l +: 8];
                            sh_co[bus.char_map_addr_o][8*l +: 8] = bus.col_map_wdata_o[8*l +: 8];
                        end
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check_eq("missing_write", bus.char_map_we_o, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int          bad;
        int          r;
        bit          found;
        logic [7:0]  b;
        logic [7:0]  co;
        logic [39:0] abcde;

        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_color_i = '0;
        for (int p = 0; p < NCELLS; p++) begin
            scr_ch[p] = '0;
            scr_co[p] = '0;
        end
        for (int w = 0; w < NWORDS; w++) begin
            sh_ch[w] = '0;
            sh_co[w] = '0;
        end
        #1 arstn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.s_ready_o, 1'b0);
        check_eq("rst_we", {bus.char_map_we_o, bus.col_map_we_o}, 2'b00);
        check_eq("rst_addr_be", {bus.char_map_addr_o, bus.char_map_be_o}, '0);
        check_eq("rst_wdata", {bus.char_map_wdata_o, bus.col_map_wdata_o}, '0);
        check_eq("rst_cursor_busy", {cur_row, cur_col, busy}, '0);
        arstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // 'A' colour 0x1F at (0,0)
        send_byte(8'h41, 8'h1F);
        check_eq("A_write", {bus.char_map_we_o, bus.char_map_addr_o, bus.char_map_be_o,
                             bus.char_map_wdata_o, bus.col_map_wdata_o},
                 {1'b1, 10'd0, 4'b0001, 32'h4141_4141, 32'h1F1F_1F1F});
        check_eq("A_cursor", {cur_row, cur_col}, {5'd0, 7'd1});

        // CR then 'ABCDE' back to back
        send_byte(8'h0D, 8'h07);
        abcde = "ABCDE";
        for (int i = 4; i >= 0; i--)
            send_byte(abcde[8*i +: 8], 8'($urandom_range(0, 255)));

        // LF at (5,0) clears row 1
        send_byte(8'h0A, 8'h2A);
        drain();
        check_eq("LF_cursor", {cur_row, cur_col}, {5'd1, 7'd0});

        // BS at col 0 and an ignored control byte
        send_byte(8'h08, 8'h11);
        send_byte(8'h07, 8'h22);
        check_eq("noop_no_we", bus.char_map_we_o, 1'b0);

        // BS at col 3
        send_byte(8'h78, 8'h33);
        send_byte(8'h79, 8'h33);
        send_byte(8'h7A, 8'h33);
        send_byte(8'h08, 8'h44);
        check_eq("BS_write", {bus.char_map_addr_o, bus.char_map_be_o, bus.char_map_wdata_o},
                 {10'd20, 4'b0100, 32'h2020_2020});
        check_eq("BS_cursor", {cur_row, cur_col}, {5'd1, 7'd2});

        // Walk to row 29, fill it, wrap into row 0
        repeat (28) send_byte(8'h0A, 8'h01);
        for (int i = 0; i < COLS; i++)
            send_byte(8'($urandom_range(32, 126)), 8'($urandom_range(0, 255)));
        drain();
        check_eq("wrap_cursor", {cur_row, cur_col}, {5'd0, 7'd0});

        // Random stream with idle gaps
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            co = 8'($urandom_range(0, 255));
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 79) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 93) b = 8'h08;
            else if (r < 95) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b, co);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        bad = 0;
        for (int p = 0; p < NCELLS; p++) begin
            if (sh_ch[p / 4][8*(p % 4) +: 8] !== scr_ch[p] || sh_co[p / 4][8*(p % 4) +: 8] !== scr_co[p])
                bad++;
        end
        check_eq("screen_cells_wrong", bad, 0);

        // FF, reset asserted while clear word 299 is on the outputs
        send_byte(8'h0C, 8'h5C);
        found = 1'b0;
        for (int i = 0; i < NWORDS + 10 && !found; i++) begin
            if (bus.char_map_we_o && bus.char_map_addr_o == 10'd299) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("ff_reached_word_299", found, 1'b1);
        mon_en = 1'b0;
        arstn  = 1'b0;
        #1;
        check_eq("abort_outputs", {bus.char_map_we_o, bus.char_map_addr_o, bus.char_map_be_o,
                                   bus.char_map_wdata_o, bus.col_map_wdata_o}, '0);
        check_eq("abort_ready_busy_cursor", {bus.s_ready_o, busy, cur_row, cur_col}, '0);
        check_eq("abort_words_left", exp_q.size(), NWORDS - 300);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        ready_cyc = 0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold_we", bus.char_map_we_o, 1'b0);
        end
        arstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        send_byte(8'h5A, 8'h66);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
